// File: rtl/tl_checker.sv
// Passive TileLink A/D/E protocol checker; message counters built only with TL_CHECKER_STATS_EN.
// Errors are registered one cycle after the offending edge; never drives ready, so never backpressures.
module tl_checker #(
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 4,
  parameter int SINK_W   = 4,
  parameter int MAX_SIZE = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [3:0]          d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SINK_W-1:0]   d_sink,
  input  logic                e_valid,
  input  logic                e_ready,
  input  logic [SINK_W-1:0]   e_sink,
  output logic                err_valid,
  output logic [3:0]          err_code,
  output logic [8:0]          err_sticky,
  output logic [31:0]         a_count,
  output logic [31:0]         d_count,
  output logic [31:0]         e_count
);
  localparam int LG_BEAT = $clog2(DATA_W / 8);
  localparam int CNT_W   = 16;
  localparam int N_SRC   = 1 << SOURCE_W;
  localparam int N_SNK   = 1 << SINK_W;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [3:0]          size;
    logic [SOURCE_W-1:0] source;
  } burst_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [3:0]          size;
    logic [SOURCE_W-1:0] source;
  } a_pay_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [3:0]          size;
    logic [SOURCE_W-1:0] source;
    logic [SINK_W-1:0]   sink;
  } d_pay_t;

  // Index of the last beat; oversized messages collapse to a single beat.
  function automatic logic [CNT_W-1:0] last_idx(input logic has_data, input logic [3:0] size);
    logic [CNT_W-1:0] idx;
    idx = '0;
    if (has_data && int'(size) <= MAX_SIZE && int'(size) > LG_BEAT)
      idx = (CNT_W'(1) << (int'(size) - LG_BEAT)) - CNT_W'(1);
    return idx;
  endfunction

  logic             a_fire, d_fire, e_fire;
  logic             a_first, a_last, d_first, d_last;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  burst_t           a_cap_q, a_cap_d, d_cap_q, d_cap_d, a_cur, d_cur;
  a_pay_t           a_prev_q, a_pay;
  d_pay_t           d_prev_q, d_pay;
  logic             a_stall_q, d_stall_q;
  logic [N_SRC-1:0] outst_q, outst_d;
  logic [N_SNK-1:0] grant_q, grant_d;
  logic [8:0]       err_vec;
  logic [3:0]       code_d;
  logic             err_valid_q;
  logic [3:0]       err_code_q;
  logic [8:0]       sticky_q;

  always_comb begin
    a_fire  = a_valid && a_ready;
    d_fire  = d_valid && d_ready;
    e_fire  = e_valid && e_ready;
    a_cur   = {a_opcode, a_size, a_source};
    d_cur   = {d_opcode, d_size, d_source};
    a_pay   = {a_opcode, a_param, a_size, a_source};
    d_pay   = {d_opcode, d_size, d_source, d_sink};
    a_first = (a_cnt_q == '0);
    d_first = (d_cnt_q == '0);
    a_last  = (a_cnt_q >= last_idx(a_opcode[2:1] == 2'b00, a_size));
    d_last  = (d_cnt_q >= last_idx(d_opcode[0], d_size));
    a_cnt_d = a_cnt_q;
    d_cnt_d = d_cnt_q;
    a_cap_d = a_cap_q;
    d_cap_d = d_cap_q;
    err_vec = '0;

    if (a_stall_q && !a_valid) err_vec[2] = 1'b1;
    if (a_stall_q && a_valid && a_pay != a_prev_q) err_vec[1] = 1'b1;
    if (d_stall_q && !d_valid) err_vec[4] = 1'b1;
    if (d_stall_q && d_valid && d_pay != d_prev_q) err_vec[3] = 1'b1;

    if (a_fire) begin
      a_cnt_d = a_last ? '0 : a_cnt_q + CNT_W'(1);
      if (a_first && !a_last) a_cap_d = a_cur;
      if (!a_first && a_cur != a_cap_q) err_vec[7] = 1'b1;
      if (int'(a_size) > MAX_SIZE) err_vec[7] = 1'b1;
      if (a_first && outst_q[a_source]) err_vec[8] = 1'b1;
    end

    if (d_fire) begin
      d_cnt_d = d_last ? '0 : d_cnt_q + CNT_W'(1);
      if (d_first && !d_last) d_cap_d = d_cur;
      if (!d_first && d_cur != d_cap_q) err_vec[7] = 1'b1;
      if (int'(d_size) > MAX_SIZE) err_vec[7] = 1'b1;
      if (d_first && d_opcode != 3'd6 && !outst_q[d_source]) err_vec[5] = 1'b1;
    end

    if (e_fire && !grant_q[e_sink]) err_vec[6] = 1'b1;

    // Clear before set so a same-cycle set wins.
    outst_d = outst_q;
    if (d_fire && d_last && d_opcode != 3'd6) outst_d[d_source] = 1'b0;
    if (a_fire && a_first) outst_d[a_source] = 1'b1;
    grant_d = grant_q;
    if (e_fire) grant_d[e_sink] = 1'b0;
    if (d_fire && d_last && (d_opcode == 3'd4 || d_opcode == 3'd5)) grant_d[d_sink] = 1'b1;

    code_d = '0;
    for (int i = 8; i >= 1; i--) begin
      if (err_vec[i]) code_d = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q     <= '0;
      d_cnt_q     <= '0;
      a_cap_q     <= '0;
      d_cap_q     <= '0;
      a_prev_q    <= '0;
      d_prev_q    <= '0;
      a_stall_q   <= 1'b0;
      d_stall_q   <= 1'b0;
      outst_q     <= '0;
      grant_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      sticky_q    <= '0;
    end else begin
      a_cnt_q     <= a_cnt_d;
      d_cnt_q     <= d_cnt_d;
      a_cap_q     <= a_cap_d;
      d_cap_q     <= d_cap_d;
      a_prev_q    <= a_pay;
      d_prev_q    <= d_pay;
      a_stall_q   <= a_valid && !a_ready;
      d_stall_q   <= d_valid && !d_ready;
      outst_q     <= outst_d;
      grant_q     <= grant_d;
      err_valid_q <= |err_vec;
      err_code_q  <= code_d;
      sticky_q    <= sticky_q | err_vec;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = sticky_q;

`ifdef TL_CHECKER_STATS_EN
  logic [31:0] a_count_q, d_count_q, e_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= '0;
      d_count_q <= '0;
      e_count_q <= '0;
    end else begin
      a_count_q <= a_count_q + 32'(a_fire && a_last);
      d_count_q <= d_count_q + 32'(d_fire && d_last);
      e_count_q <= e_count_q + 32'(e_fire);
    end
  end

  assign a_count = a_count_q;
  assign d_count = d_count_q;
  assign e_count = e_count_q;
`else
  assign a_count = '0;
  assign d_count = '0;
  assign e_count = '0;
`endif

endmodule

// File: tb/tb_tl_checker.sv
// Bench for tl_checker: directed scenarios then randomized traffic against a message-level model.
module tb_tl_checker;
  localparam int DATA_W   = 64;
  localparam int SOURCE_W = 4;
  localparam int SINK_W   = 4;
  localparam int MAX_SIZE = 6;
  localparam int N_SRC    = 1 << SOURCE_W;
  localparam int N_SNK    = 1 << SINK_W;
`ifdef TL_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                a_valid, a_ready;
  logic [2:0]          a_opcode, a_param;
  logic [3:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic                d_valid, d_ready;
  logic [2:0]          d_opcode;
  logic [3:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic [SINK_W-1:0]   d_sink;
  logic                e_valid, e_ready;
  logic [SINK_W-1:0]   e_sink;
  logic                err_valid;
  logic [3:0]          err_code;
  logic [8:0]          err_sticky;
  logic [31:0]         a_count, d_count, e_count;

  tl_checker #(.DATA_W(DATA_W), .SOURCE_W(SOURCE_W), .SINK_W(SINK_W), .MAX_SIZE(MAX_SIZE)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink),
    .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .a_count(a_count), .d_count(d_count), .e_count(e_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Message-level reference model: beats remaining per channel, ownership as bit arrays.
  int          ma_left, md_left;
  int          ma_cop, ma_csz, ma_csrc, md_cop, md_csz, md_csrc;
  bit          ma_stall, md_stall;
  int          ma_pop, ma_ppar, ma_psz, ma_psrc, md_pop, md_psz, md_psrc, md_psnk;
  bit          m_out[N_SRC];
  bit          m_grant[N_SNK];
  logic [31:0] m_acnt, m_dcnt, m_ecnt;
  bit          m_exp_valid, m_in_rst;
  int          m_exp_code;
  logic [8:0]  m_exp_sticky;

  function automatic int beats_of(input bit has_data, input int size);
    int b;
    if (!has_data || size > MAX_SIZE) return 1;
    b = (1 << size) / (DATA_W / 8);
    return (b < 1) ? 1 : b;
  endfunction

  task automatic model_step();
    logic [8:0] m;
    bit a_set, d_clr, g_set, g_clr;
    m = '0;
    a_set = 0; d_clr = 0; g_set = 0; g_clr = 0;
    if (rst) begin
      ma_left = 0; md_left = 0; ma_stall = 0; md_stall = 0;
      for (int i = 0; i < N_SRC; i++) m_out[i] = 0;
      for (int i = 0; i < N_SNK; i++) m_grant[i] = 0;
      m_acnt = 0; m_dcnt = 0; m_ecnt = 0;
      m_exp_valid = 0; m_exp_code = 0; m_exp_sticky = '0; m_in_rst = 1;
      return;
    end
    m_in_rst = 0;
    if (ma_stall) begin
      if (!a_valid) m[2] = 1;
      else if (int'(a_opcode) != ma_pop || int'(a_param) != ma_ppar ||
               int'(a_size) != ma_psz || int'(a_source) != ma_psrc) m[1] = 1;
    end
    if (md_stall) begin
      if (!d_valid) m[4] = 1;
      else if (int'(d_opcode) != md_pop || int'(d_size) != md_psz ||
               int'(d_source) != md_psrc || int'(d_sink) != md_psnk) m[3] = 1;
    end
    if (a_valid && a_ready) begin
      if (int'(a_size) > MAX_SIZE) m[7] = 1;
      if (ma_left == 0) begin
        if (m_out[a_source]) m[8] = 1;
        a_set = 1;
        ma_left = beats_of(a_opcode <= 3'd1, int'(a_size));
        ma_cop = int'(a_opcode); ma_csz = int'(a_size); ma_csrc = int'(a_source);
      end else if (int'(a_opcode) != ma_cop || int'(a_size) != ma_csz || int'(a_source) != ma_csrc) begin
        m[7] = 1;
      end
      ma_left--;
      if (ma_left == 0) m_acnt++;
    end
    if (d_valid && d_ready) begin
      if (int'(d_size) > MAX_SIZE) m[7] = 1;
      if (md_left == 0) begin
        if (d_opcode != 3'd6 && !m_out[d_source]) m[5] = 1;
        md_left = beats_of(!(d_opcode inside {3'd0, 3'd2, 3'd4, 3'd6}), int'(d_size));
        md_cop = int'(d_opcode); md_csz = int'(d_size); md_csrc = int'(d_source);
      end else if (int'(d_opcode) != md_cop || int'(d_size) != md_csz || int'(d_source) != md_csrc) begin
        m[7] = 1;
      end
      md_left--;
      if (md_left == 0) begin
        m_dcnt++;
        if (d_opcode != 3'd6) d_clr = 1;
        if (d_opcode == 3'd4 || d_opcode == 3'd5) g_set = 1;
      end
    end
    if (e_valid && e_ready) begin
      if (!m_grant[e_sink]) m[6] = 1;
      g_clr = 1;
      m_ecnt++;
    end
    if (d_clr) m_out[d_source] = 0;
    if (a_set) m_out[a_source] = 1;
    if (g_clr) m_grant[e_sink] = 0;
    if (g_set) m_grant[d_sink] = 1;
    ma_stall = a_valid && !a_ready;
    md_stall = d_valid && !d_ready;
    ma_pop = int'(a_opcode); ma_ppar = int'(a_param); ma_psz = int'(a_size); ma_psrc = int'(a_source);
    md_pop = int'(d_opcode); md_psz = int'(d_size); md_psrc = int'(d_source); md_psnk = int'(d_sink);
    m_exp_valid = (m != '0);
    m_exp_code = 0;
    for (int c = 1; c <= 8; c++) begin
      if (m[c]) begin
        m_exp_code = c;
        break;
      end
    end
    m_exp_sticky = m_exp_sticky | m;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("err_valid", 32'(err_valid), 32'(m_exp_valid));
    if (m_exp_valid || m_in_rst) check_val("err_code", 32'(err_code), 32'(m_exp_code));
    check_val("err_sticky", 32'(err_sticky), 32'(m_exp_sticky));
    check_val("a_count", a_count, STATS ? m_acnt : 32'd0);
    check_val("d_count", d_count, STATS ? m_dcnt : 32'd0);
    check_val("e_count", e_count, STATS ? m_ecnt : 32'd0);
  endtask

  task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [SOURCE_W-1:0] src);
    int n;
    n = beats_of(op <= 3'd1, int'(sz));
    a_valid = 1; a_ready = 1; a_opcode = op; a_param = 0; a_size = sz; a_source = src;
    repeat (n) tick();
    a_valid = 0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [3:0] sz, input logic [SOURCE_W-1:0] src,
                        input logic [SINK_W-1:0] snk);
    int n;
    n = beats_of(!(op inside {3'd0, 3'd2, 3'd4, 3'd6}), int'(sz));
    d_valid = 1; d_ready = 1; d_opcode = op; d_size = sz; d_source = src; d_sink = snk;
    repeat (n) tick();
    d_valid = 0;
  endtask

  task automatic send_e(input logic [SINK_W-1:0] snk);
    e_valid = 1; e_ready = 1; e_sink = snk;
    tick();
    e_valid = 0;
  endtask

  initial begin
    bit a_pend, d_pend, a_stl, d_stl, a_fired, d_fired;
    int a_left, d_left;
    rst = 1;
    a_valid = 0; a_ready = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    d_valid = 0; d_ready = 0; d_opcode = 0; d_size = 0; d_source = 0; d_sink = 0;
    e_valid = 0; e_ready = 0; e_sink = 0;
    repeat (2) tick();
    check_val("rst_err_valid", 32'(err_valid), 32'd0);
    check_val("rst_sticky", 32'(err_sticky), 32'd0);
    rst = 0;
    tick();

    // 8-beat PutFullData followed by AccessAck.
    send_a(3'd0, 4'd6, 4'd3);
    send_d(3'd0, 4'd6, 4'd3, 4'd0);
    check_val("put_no_err", 32'(err_valid), 32'd0);
    check_val("put_sticky", 32'(err_sticky), 32'd0);
    check_val("put_a_count", a_count, STATS ? 32'd1 : 32'd0);
    check_val("put_d_count", d_count, STATS ? 32'd1 : 32'd0);

    // Source changes while stalled.
    a_valid = 1; a_ready = 0; a_opcode = 3'd4; a_param = 0; a_size = 4'd2; a_source = 4'd3;
    tick();
    a_source = 4'd4;
    tick();
    check_val("unstable_valid", 32'(err_valid), 32'd1);
    check_val("unstable_code", 32'(err_code), 32'd1);
    check_val("unstable_sticky1", 32'(err_sticky[1]), 32'd1);
    a_ready = 1;
    tick();
    a_valid = 0;

    // Response with no request.
    send_d(3'd0, 4'd2, 4'd5, 4'd0);
    check_val("noreq_code", 32'(err_code), 32'd5);

    // Acquire / GrantData / GrantAck, then a duplicate GrantAck.
    send_a(3'd6, 4'd6, 4'd2);
    send_d(3'd5, 4'd6, 4'd2, 4'd1);
    send_e(4'd1);
    check_val("e_first_ok", 32'(err_valid), 32'd0);
    send_e(4'd1);
    check_val("e_second_valid", 32'(err_valid), 32'd1);
    check_val("e_second_code", 32'(err_code), 32'd6);

    // Reset in the middle of a burst.
    a_valid = 1; a_ready = 1; a_opcode = 3'd0; a_param = 0; a_size = 4'd6; a_source = 4'd7;
    repeat (3) tick();
    rst = 1; a_valid = 0;
    tick();
    check_val("mid_rst_sticky", 32'(err_sticky), 32'd0);
    check_val("mid_rst_code", 32'(err_code), 32'd0);
    check_val("mid_rst_acount", a_count, 32'd0);
    tick();
    rst = 0;
    tick();
    send_a(3'd4, 4'd3, 4'd9);
    tick();
    check_val("post_rst_valid", 32'(err_valid), 32'd0);
    check_val("post_rst_sticky", 32'(err_sticky), 32'd0);

    // Opcode change mid-burst.
    a_valid = 1; a_ready = 1; a_opcode = 3'd0; a_param = 0; a_size = 4'd5; a_source = 4'd10;
    tick();
    a_opcode = 3'd1;
    tick();
    check_val("mismatch_code", 32'(err_code), 32'd7);
    repeat (2) tick();
    a_valid = 0;

    // Oversized request.
    send_a(3'd4, 4'd7, 4'd11);
    check_val("oversize_code", 32'(err_code), 32'd7);

    // Drop and bad GrantAck in the same cycle: lower code wins, both sticky.
    a_valid = 1; a_ready = 0; a_opcode = 3'd4; a_size = 4'd2; a_source = 4'd13;
    tick();
    a_valid = 0; e_valid = 1; e_ready = 1; e_sink = 4'd3;
    tick();
    e_valid = 0;
    check_val("simul_code", 32'(err_code), 32'd2);
    check_val("simul_sticky26", 32'({err_sticky[6], err_sticky[2]}), 32'd3);

    // Same-cycle set and clear of one source leaves it outstanding.
    send_a(3'd4, 4'd2, 4'd12);
    a_valid = 1; a_ready = 1; a_opcode = 3'd4; a_size = 4'd2; a_source = 4'd12;
    d_valid = 1; d_ready = 1; d_opcode = 3'd0; d_size = 4'd2; d_source = 4'd12; d_sink = 0;
    tick();
    a_valid = 0; d_valid = 0;
    check_val("setclr_code", 32'(err_code), 32'd8);
    send_d(3'd0, 4'd2, 4'd12, 4'd0);
    check_val("setclr_kept", 32'(err_valid), 32'd0);

    // Randomized traffic.
    a_pend = 0; d_pend = 0; a_stl = 0; d_stl = 0; a_left = 0; d_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1; a_valid = 0; d_valid = 0; e_valid = 0;
        a_pend = 0; d_pend = 0; a_stl = 0; d_stl = 0;
        tick();
        rst = 0;
        continue;
      end
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_opcode = 3'($urandom_range(0, 7));
        a_size = 4'($urandom_range(0, 7));
        a_source = SOURCE_W'($urandom_range(0, N_SRC - 1));
        a_param = 3'($urandom_range(0, 7));
        a_left = beats_of(a_opcode <= 3'd1, int'(a_size));
        a_pend = 1;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0: d_opcode = 3'd0;
          1: d_opcode = 3'd1;
          2: d_opcode = 3'd4;
          3: d_opcode = 3'd5;
          default: d_opcode = 3'd6;
        endcase
        d_size = 4'($urandom_range(0, 7));
        d_source = SOURCE_W'($urandom_range(0, N_SRC - 1));
        d_sink = SINK_W'($urandom_range(0, 3));
        d_left = beats_of(!(d_opcode inside {3'd0, 3'd2, 3'd4, 3'd6}), int'(d_size));
        d_pend = 1;
      end
      a_valid = a_pend && !(a_stl && $urandom_range(0, 15) == 0);
      d_valid = d_pend && !(d_stl && $urandom_range(0, 15) == 0);
      if (a_stl && a_valid && $urandom_range(0, 15) == 0) a_param = a_param + 3'd1;
      if (d_stl && d_valid && $urandom_range(0, 15) == 0) d_sink = d_sink + 1'b1;
      a_ready = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      e_valid = ($urandom_range(0, 3) == 0);
      e_ready = ($urandom_range(0, 1) == 0);
      e_sink = SINK_W'($urandom_range(0, 3));
      a_fired = a_valid && a_ready;
      d_fired = d_valid && d_ready;
      tick();
      if (a_fired) begin
        a_left--;
        if (a_left == 0) a_pend = 0;
      end
      if (d_fired) begin
        d_left--;
        if (d_left == 0) d_pend = 0;
      end
      a_stl = a_valid && !a_ready;
      d_stl = d_valid && !d_ready;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
